alu_stream: RTL and testbench

//  Parametrised, handshaked successor of the single-cycle 8-bit ALU. Accepts one operation per
//  in_valid/in_ready transfer and returns result + flags via out_valid/out_ready.

---
 rtl/alu_stream_pkg.sv | 31 +++
 rtl/alu_stream_if.sv | 29 ++
 rtl/alu_stream_mul.sv | 60 ++++++
 rtl/alu_stream.sv | 137 +++++++++++++
 tb/tb_alu_stream.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_stream_pkg.sv
// Shared types and constants for the handshaked ALU: opcode encoding, flag bit positions
// and FSM state codes.
package alu_stream_pkg;

    localparam int OPW = 4;

    typedef enum logic [OPW-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_SHR  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } op_e;

    // flags bus layout is {ovf, neg, zero, carry}
    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_OVF   = 3;

    typedef logic [0:0] state_e;
    localparam state_e ST_IDLE = 1'b0;
    localparam state_e ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_stream_if.sv
// Operation/result handshake bundle between the stimulus driver (master) and the ALU (slave).
interface alu_stream_if
    import alu_stream_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, flags, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, flags, err
    );

endinterface

// File: rtl/alu_stream_mul.sv
// Iterative shift-add multiplier: one partial product per cycle for WIDTH cycles. done and
// product are presented combinationally during the final iteration so the caller can load them.
module alu_stream_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               busy_reg;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_next;

    // partial product: shifted multiplicand gated by the current multiplier LSB
    for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
        assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end

    assign acc_next = acc_reg + addend;
    assign busy     = busy_reg;
    assign done     = busy_reg && (cnt_reg == CNT_W'(WIDTH-1));
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            busy_reg   <= 1'b0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else if (start) begin
            busy_reg   <= 1'b1;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_stream.sv
// Handshaked ALU: single-cycle ops load the output registers on the accepting edge; MUL hands
// off to the iterative multiplier and blocks new input until its result is loaded.
module alu_stream
    import alu_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    alu_stream_if.slave  bus
);

    localparam int SH_W = $clog2(WIDTH);

    state_e             state_reg;
    logic               out_valid_reg;
    logic [WIDTH-1:0]   result_reg;
    logic [3:0]         flags_reg;
    logic               err_reg;

    logic               accept;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [3:0]         mul_flags;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH-1:0]   sub_diff;
    logic [SH_W-1:0]    sh;
    logic [WIDTH-1:0]   alu_result;
    logic [3:0]         alu_flags;
    logic               alu_err;
    logic               alu_carry;
    logic               alu_ovf;

    assign bus.in_ready  = (state_reg == ST_IDLE) && !mul_busy
                           && (!out_valid_reg || bus.out_ready) && !rst;
    assign accept        = bus.in_valid && bus.in_ready;
    assign mul_start     = accept && (bus.op == OP_MUL);
    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;
    assign bus.flags     = flags_reg;
    assign bus.err       = err_reg;

    alu_stream_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .srst    (rst),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign add_sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_diff = bus.a - bus.b;
    assign sh       = bus.b[SH_W-1:0];

    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
        alu_err    = 1'b0;
        case (op_e'(bus.op))
            OP_ADD: begin
                alu_result = add_sum[WIDTH-1:0];
                alu_carry  = add_sum[WIDTH];
                alu_ovf    = (bus.a[WIDTH-1] == bus.b[WIDTH-1])
                             && (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = sub_diff;
                alu_carry  = (bus.a >= bus.b);
                alu_ovf    = (bus.a[WIDTH-1] != bus.b[WIDTH-1])
                             && (sub_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  alu_result = bus.a & bus.b;
            OP_OR:   alu_result = bus.a | bus.b;
            OP_XOR:  alu_result = bus.a ^ bus.b;
            OP_SHL:  alu_result = bus.a << sh;
            OP_SHR:  alu_result = bus.a >> sh;
            OP_SRA:  alu_result = $unsigned($signed(bus.a) >>> sh);
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_MUL:  alu_result = '0;
            default: alu_err    = 1'b1;
        endcase
        alu_flags = '0;
        if (!alu_err) begin
            alu_flags[FLAG_CARRY] = alu_carry;
            alu_flags[FLAG_ZERO]  = (alu_result == '0);
            alu_flags[FLAG_NEG]   = alu_result[WIDTH-1];
            alu_flags[FLAG_OVF]   = alu_ovf;
        end
    end

    // MUL carry reports a nonzero high half of the full product
    always_comb begin
        mul_flags             = '0;
        mul_flags[FLAG_CARRY] = |mul_product[2*WIDTH-1:WIDTH];
        mul_flags[FLAG_ZERO]  = (mul_product[WIDTH-1:0] == '0);
        mul_flags[FLAG_NEG]   = mul_product[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            flags_reg     <= '0;
            err_reg       <= 1'b0;
        end else begin
            if (accept && !mul_start) begin
                out_valid_reg <= 1'b1;
                result_reg    <= alu_result;
                flags_reg     <= alu_flags;
                err_reg       <= alu_err;
            end else if (mul_done) begin
                out_valid_reg <= 1'b1;
                result_reg    <= mul_product[WIDTH-1:0];
                flags_reg     <= mul_flags;
                err_reg       <= 1'b0;
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end

            if (mul_start) begin
                state_reg <= ST_MUL;
            end else if (mul_done) begin
                state_reg <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_alu_stream.sv
// Directed plus randomized checks of alu_stream (WIDTH=8) against an integer-arithmetic model.
module tb_alu_stream;

    typedef struct packed {
        logic       err;
        logic [3:0] flags;
        logic [7:0] result;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_stream_if #(.WIDTH(8)) bus ();

    alu_stream #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t ref_model(input int a, input int b, input int op);
        exp_t e;
        int sa, sb, s, r, sh;
        bit c, v;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sh = b % 8;
        r = 0; c = 0; v = 0;
        case (op)
            0:  begin s = a + b; r = s % 256; c = (s > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            1:  begin r = (a + 256 - b) % 256; c = (a >= b); v = (sa - sb > 127) || (sa - sb < -128); end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = (a * (1 << sh)) % 256;
            6:  r = a / (1 << sh);
            7:  r = (sa >>> sh) & 255;
            8:  r = (sa < sb) ? 1 : 0;
            9:  r = (a < b) ? 1 : 0;
            10: begin s = a * b; r = s % 256; c = (s > 255); end
            default: begin
                e.err = 1'b1; e.flags = 4'b0; e.result = 8'h00;
                return e;
            end
        endcase
        e.err    = 1'b0;
        e.result = r[7:0];
        e.flags  = {v, (r >= 128), (r == 0), c};
        return e;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one op with out_ready=1, wait for its result, check latency and value; ends on a negedge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         output exp_t obs);
        exp_t e;
        int   waitc, lat;
        bit   ir_seen;
        e = ref_model(int'(a), int'(b), int'(op));
        bus.a = a; bus.b = b; bus.op = op;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        waitc = 0;
        while (!bus.in_ready && waitc < 20) begin
            @(negedge clk); #1;
            waitc++;
        end
        check("accept_wait", 16'(waitc < 20), 16'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1; ir_seen = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) ir_seen = 1;
            @(negedge clk);
            lat++;
        end
        check("latency", 16'(lat), (op == 4'd10) ? 16'd9 : 16'd1);
        if (op == 4'd10) check("mul_in_ready_low", 16'(ir_seen), 16'd0);
        obs = '{err: bus.err, flags: bus.flags, result: bus.result};
        check("model", 16'(obs), 16'(e));
        $display("op=%0d a=%02h b=%02h -> result=%02h flags=%04b err=%0d lat=%0d",
                 op, a, b, obs.result, obs.flags, obs.err, lat);
    endtask

    initial begin
        exp_t       obs, e;
        logic [7:0] la[4], lb[4];
        logic [3:0] lop[4];
        bit         seen;

        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.op = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 16'(bus.in_ready), 16'd0);
        check("rst_out_valid", 16'(bus.out_valid), 16'd0);
        check("rst_result", 16'(bus.result), 16'd0);
        check("rst_flags", 16'(bus.flags), 16'd0);
        check("rst_err", 16'(bus.err), 16'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 16'(bus.in_ready), 16'd1);
        @(negedge clk);

        // directed corner cases
        issue(8'hFF, 8'h01, 4'd0, obs);
        check("add_result", 16'(obs.result), 16'h00);
        check("add_flags", 16'(obs.flags), 16'b0011);
        issue(8'h80, 8'h01, 4'd1, obs);
        check("sub_result", 16'(obs.result), 16'h7F);
        check("sub_flags", 16'(obs.flags), 16'b1001);
        issue(8'hFF, 8'h01, 4'd8, obs);
        check("slt_result", 16'(obs.result), 16'h01);
        issue(8'h10, 8'h11, 4'd10, obs);
        check("mul_result", 16'(obs.result), 16'h10);
        check("mul_carry", 16'(obs.flags[0]), 16'd1);
        issue(8'h33, 8'h44, 4'd12, obs);
        check("illegal_err", 16'(obs.err), 16'd1);
        check("illegal_result", 16'(obs.result), 16'd0);
        check("illegal_flags", 16'(obs.flags), 16'd0);
        issue(8'h01, 8'h02, 4'd0, obs);
        check("err_cleared", 16'(obs.err), 16'd0);

        // randomized ops, all opcodes including MUL and illegal
        for (int i = 0; i < 40; i++) begin
            issue(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), obs);
        end

        // backpressure: XOR result held, then consume+accept and 4 back-to-back ops
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.a = 8'h5A; bus.b = 8'h0F; bus.op = 4'd4;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        #1;
        check("bp_first_accept", 16'(bus.in_ready), 16'd1);
        @(posedge clk);
        @(negedge clk);
        check("bp_xor_valid", 16'(bus.out_valid), 16'd1);
        check("bp_xor_result", 16'(bus.result), 16'h55);
        for (int i = 0; i < 4; i++) begin
            la[i] = 8'($urandom); lb[i] = 8'($urandom); lop[i] = 4'($urandom_range(0, 9));
        end
        bus.a = la[0]; bus.b = lb[0]; bus.op = lop[0];
        #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_in_ready_low", 16'(bus.in_ready), 16'd0);
            check("bp_hold", 16'(bus.result), 16'h55);
            @(negedge clk); #1;
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.a = la[i]; bus.b = lb[i]; bus.op = lop[i];
            #1;
            check("b2b_in_ready", 16'(bus.in_ready), 16'd1);
            @(posedge clk);
            @(negedge clk);
            e = ref_model(int'(la[i]), int'(lb[i]), int'(lop[i]));
            check("b2b_valid", 16'(bus.out_valid), 16'd1);
            check("b2b_model", 16'({bus.err, bus.flags, bus.result}), 16'(e));
            $display("b2b op=%0d a=%02h b=%02h -> result=%02h", lop[i], la[i], lb[i], bus.result);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_drained", 16'(bus.out_valid), 16'd0);

        // reset in the middle of a MUL
        issue(8'h12, 8'h34, 4'd0, obs);
        @(negedge clk);
        bus.a = 8'hC3; bus.b = 8'h5D; bus.op = 4'd10; bus.in_valid = 1'b1;
        #1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midmul_in_ready", 16'(bus.in_ready), 16'd0);
        check("midmul_out_valid", 16'(bus.out_valid), 16'd0);
        check("midmul_result", 16'(bus.result), 16'd0);
        check("midmul_flags", 16'(bus.flags), 16'd0);
        rst = 1'b0;
        #1;
        check("midmul_in_ready_after", 16'(bus.in_ready), 16'd1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check("midmul_no_stale", 16'(seen), 16'd0);
        $display("mid-MUL reset: out_valid stayed %0d", seen);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
